magazine_ctrl: RTL and testbench

//  Ammunition controller for Duck Hunt. Sequences shots, cooldown and reload, and owns
//  the 3-bit bullet count that drives the magazine overlay (draw stage) and the hit

---
 rtl/magazine_if.sv | 26 ++
 rtl/magazine_ctrl.sv | 133 +++++++++++++
 tb/tb_magazine_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/magazine_if.sv
// Handshake bundle between the game/mouse side and the ammunition controller.
// The master drives the controls and cursor position; the slave reports ammo state and shot events.
interface magazine_if;
  logic        game_enable;
  logic        round_refill;
  logic        trigger;
  logic        reload_req;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [2:0]  bullets_in_magazine;
  logic        shot_valid;
  logic [11:0] shot_x;
  logic [11:0] shot_y;
  logic        dry_fire;
  logic        reloading;

  modport master (
    output game_enable, round_refill, trigger, reload_req, xpos, ypos,
    input  bullets_in_magazine, shot_valid, shot_x, shot_y, dry_fire, reloading
  );

  modport slave (
    input  game_enable, round_refill, trigger, reload_req, xpos, ypos,
    output bullets_in_magazine, shot_valid, shot_x, shot_y, dry_fire, reloading
  );
endinterface

// File: rtl/magazine_ctrl.sv
// Duck Hunt ammunition controller: sequences shots, cooldown and reload, owns the bullet count
// and emits one-cycle shot / dry-fire pulses with the latched aim point.
module magazine_ctrl #(
  parameter int MAG_SIZE        = 3,
  parameter int COOLDOWN_CYCLES = 16_250_000,
  parameter int RELOAD_CYCLES   = 32_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  magazine_if.slave  bus
);

  localparam int MAX_CYCLES = (COOLDOWN_CYCLES > RELOAD_CYCLES) ? COOLDOWN_CYCLES : RELOAD_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0]    MAG     = 3'(MAG_SIZE);
  localparam logic [CW-1:0] CD_LAST = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [CW-1:0] RL_LAST = CW'(RELOAD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_DISABLED,
    S_READY,
    S_COOLDOWN,
    S_EMPTY,
    S_RELOADING
  } state_t;

  state_t        state;
  logic [2:0]    bullets;
  logic [CW-1:0] cnt;
  logic          trig_q;
  logic          shot_valid;
  logic          dry_fire;
  logic          reloading;
  logic [11:0]   shot_x;
  logic [11:0]   shot_y;
  logic          fire_edge;

  // trig_q follows the button in every state, so a press held across enable or cooldown never fires.
  assign fire_edge = bus.trigger & ~trig_q;

  // NOTE: every register in this block uses <= so all updates see the pre-edge values;
  // the async reset returns the whole controller to a known state without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_DISABLED;
      bullets    <= MAG;
      cnt        <= '0;
      trig_q     <= 1'b0;
      shot_valid <= 1'b0;
      dry_fire   <= 1'b0;
      reloading  <= 1'b0;
      shot_x     <= '0;
      shot_y     <= '0;
    end else begin
      trig_q     <= bus.trigger;
      shot_valid <= 1'b0;
      dry_fire   <= 1'b0;

      if (!bus.game_enable) begin
        state     <= S_DISABLED;
        bullets   <= MAG;
        cnt       <= '0;
        reloading <= 1'b0;
      end else if (bus.round_refill) begin
        state     <= S_READY;
        bullets   <= MAG;
        cnt       <= '0;
        reloading <= 1'b0;
      end else begin
        unique case (state)
          S_DISABLED: state <= S_READY;

          S_READY: begin
            if (fire_edge && bullets != 3'd0) begin
              bullets    <= bullets - 3'd1;
              shot_valid <= 1'b1;
              shot_x     <= bus.xpos;
              shot_y     <= bus.ypos;
              cnt        <= '0;
              state      <= S_COOLDOWN;
            end else if (bus.reload_req && bullets < MAG) begin
              cnt       <= '0;
              reloading <= 1'b1;
              state     <= S_RELOADING;
            end
          end

          S_COOLDOWN: begin
            if (cnt == CD_LAST) begin
              cnt   <= '0;
              state <= (bullets != 3'd0) ? S_READY : S_EMPTY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          S_EMPTY: begin
            if (fire_edge) dry_fire <= 1'b1;
            if (bus.reload_req) begin
              cnt       <= '0;
              reloading <= 1'b1;
              state     <= S_RELOADING;
            end
          end

          S_RELOADING: begin
            if (cnt == RL_LAST) begin
              cnt <= '0;
              if (bullets < MAG) bullets <= bullets + 3'd1;
              if (bullets + 3'd1 >= MAG) begin
                reloading <= 1'b0;
                state     <= S_READY;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: state <= S_DISABLED;
        endcase
      end
    end
  end

  assign bus.bullets_in_magazine = bullets;
  assign bus.shot_valid          = shot_valid;
  assign bus.shot_x              = shot_x;
  assign bus.shot_y              = shot_y;
  assign bus.dry_fire            = dry_fire;
  assign bus.reloading           = reloading;

endmodule

// File: tb/tb_magazine_ctrl.sv
// Scoreboard bench for magazine_ctrl: the driver queues expected shot/dry-fire events,
// a monitor pops and compares them whenever the controller emits a pulse.
module tb_magazine_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  magazine_if bus ();

  magazine_ctrl #(
    .MAG_SIZE       (3),
    .COOLDOWN_CYCLES(4),
    .RELOAD_CYCLES  (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        is_dry;
    logic [11:0] x;
    logic [11:0] y;
    logic [2:0]  bullets;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sets the trigger level that the next rising edge samples, then waits just past that edge.
  task automatic step(input logic t);
    bus.trigger = t;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_shot(input logic [11:0] x, input logic [11:0] y, input logic [2:0] b);
    ev_t e;
    bus.xpos = x;
    bus.ypos = y;
    e = '{is_dry: 1'b0, x: x, y: y, bullets: b, cyc: cyc + 1};
    exp_q.push_back(e);
  endtask

  task automatic expect_dry();
    ev_t e;
    e = '{is_dry: 1'b1, x: 12'd0, y: 12'd0, bullets: 3'd0, cyc: cyc + 1};
    exp_q.push_back(e);
  endtask

  task automatic pulse_reload();
    bus.reload_req = 1'b1;
    step(1'b0);
    bus.reload_req = 1'b0;
  endtask

  // Monitor: every emitted pulse must match the oldest queued expectation.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.shot_valid || bus.dry_fire)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, bus.shot_valid, bus.dry_fire}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ev_cycle", cyc, e.cyc);
          check("ev_shot_valid", bus.shot_valid, !e.is_dry);
          check("ev_dry_fire", bus.dry_fire, e.is_dry);
          check("ev_bullets", bus.bullets_in_magazine, e.bullets);
          if (!e.is_dry) begin
            check("ev_shot_x", bus.shot_x, e.x);
            check("ev_shot_y", bus.shot_y, e.y);
          end
        end
      end
    end
  end

  initial begin
    bus.game_enable  = 1'b0;
    bus.round_refill = 1'b0;
    bus.trigger      = 1'b0;
    bus.reload_req   = 1'b0;
    bus.xpos         = 12'd0;
    bus.ypos         = 12'd0;

    // Reset values
    #23;
    check("rst_bullets", bus.bullets_in_magazine, 3);
    check("rst_shot_valid", bus.shot_valid, 0);
    check("rst_dry_fire", bus.dry_fire, 0);
    check("rst_reloading", bus.reloading, 0);
    check("rst_shot_x", bus.shot_x, 0);
    #4 rst_n = 1'b1;
    step(1'b0);
    step(1'b0);

    // Trigger held while the game is enabled must not fire
    bus.game_enable = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1);
    step(1'b0);
    check("held_no_shot_bullets", bus.bullets_in_magazine, 3);

    // First shot with latched aim point
    expect_shot(12'd500, 12'd300, 3'd2);
    step(1'b1);
    check("shot1_bullets", bus.bullets_in_magazine, 2);
    bus.xpos = 12'd999;
    bus.ypos = 12'd999;
    step(1'b0);
    check("shot1_pulse_width", bus.shot_valid, 0);
    check("shot1_x_held", bus.shot_x, 500);
    step(1'b0);
    step(1'b0);
    step(1'b1);                      // sampled 4 edges after the shot: still cooling down
    step(1'b0);
    check("cd_block_bullets", bus.bullets_in_magazine, 2);
    expect_shot(12'd10, 12'd20, 3'd1);
    step(1'b1);                      // 6 edges after shot 1
    for (int i = 0; i < 4; i++) step(1'b0);
    expect_shot(12'd4095, 12'd0, 3'd0);
    step(1'b1);                      // exactly 5 edges after shot 2: cooldown is 4 cycles
    step(1'b0);
    step(1'b1);                      // edge during cooldown with empty magazine: no dry fire
    step(1'b0);
    step(1'b0);
    expect_dry();
    step(1'b1);
    step(1'b0);
    check("empty_bullets", bus.bullets_in_magazine, 0);

    // Reload from empty, trigger edges during reload are ignored
    pulse_reload();
    check("reload_flag_on", bus.reloading, 1);
    for (int i = 1; i <= 24; i++) begin
      step(i == 4 || i == 12);
      if (i == 7)  check("reload_b_at7", bus.bullets_in_magazine, 0);
      if (i == 8)  check("reload_b_at8", bus.bullets_in_magazine, 1);
      if (i == 16) check("reload_b_at16", bus.bullets_in_magazine, 2);
      if (i == 23) check("reload_flag_at23", bus.reloading, 1);
      if (i == 24) begin
        check("reload_b_at24", bus.bullets_in_magazine, 3);
        check("reload_flag_at24", bus.reloading, 0);
      end
    end

    // Reload request with a full magazine is ignored
    pulse_reload();
    check("full_reload_ignored", bus.reloading, 0);

    // Refill mid-reload with one bullet left
    expect_shot(12'd7, 12'd8, 3'd2);
    step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    expect_shot(12'd9, 12'd11, 3'd1);
    step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    pulse_reload();
    step(1'b0);
    step(1'b0);
    check("mid_reload_bullets", bus.bullets_in_magazine, 1);
    bus.round_refill = 1'b1;
    step(1'b1);                      // same-cycle trigger edge is ignored by the refill
    bus.round_refill = 1'b0;
    check("refill_bullets", bus.bullets_in_magazine, 3);
    check("refill_reloading", bus.reloading, 0);
    step(1'b0);
    expect_shot(12'd1234, 12'd77, 3'd2);
    step(1'b1);                      // READY right away after refill

    // Disable mid-cooldown
    bus.game_enable = 1'b0;
    step(1'b0);
    check("disable_bullets", bus.bullets_in_magazine, 3);
    step(1'b1);
    step(1'b0);
    bus.game_enable = 1'b1;
    step(1'b0);
    step(1'b0);

    // Async reset mid-reload, asserted away from the clock edge
    expect_shot(12'd321, 12'd654, 3'd2);
    step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    pulse_reload();
    step(1'b0);
    step(1'b0);
    check("pre_rst_reloading", bus.reloading, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bullets", bus.bullets_in_magazine, 3);
    check("async_rst_reloading", bus.reloading, 0);
    check("async_rst_shot_x", bus.shot_x, 0);
    check("async_rst_shot_y", bus.shot_y, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
